// File: rtl/run_sprite_pkg.sv
// Shared types and default geometry for the running-character sprite fetch path.
package run_sprite_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } anim_state_t;

    localparam int           DEF_SPR_W           = 32;
    localparam int           DEF_SPR_H           = 48;
    localparam int           DEF_NUM_FRAMES      = 4;
    localparam int           DEF_FRAME_HOLD      = 6;
    localparam logic [3:0]   DEF_TRANSPARENT_IDX = 4'h0;

    // Counter width that stays legal when the count collapses to one value.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_anim_ctrl.sv
// Vsync tick detection, per-frame shadow copies of the sprite position and
// the IDLE/RUN animation sequencer that selects the current ROM frame.
module run_anim_ctrl
    import run_sprite_pkg::*;
#(
    parameter int NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int FRAME_HOLD = DEF_FRAME_HOLD,
    parameter int FRAME_W    = cnt_w(NUM_FRAMES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               vs_i,
    input  logic [9:0]         pos_x_i,
    input  logic [9:0]         pos_y_i,
    input  logic               facing_left_i,
    input  logic               running_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic [9:0]         pos_x_o,
    output logic [9:0]         pos_y_o,
    output logic               facing_left_o
);

    localparam int HOLD_W = cnt_w(FRAME_HOLD);

    logic               vs_d_q;
    logic               tick_s;
    logic [9:0]         pos_x_q, pos_y_q;
    logic               facing_q;
    anim_state_t        state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    assign tick_s = vs_d_q & ~vs_i;

    // Vsync delay and shadow capture; running is consumed directly by the FSM at the tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_d_q   <= 1'b1;
            pos_x_q  <= 10'd0;
            pos_y_q  <= 10'd0;
            facing_q <= 1'b0;
        end else begin
            vs_d_q <= vs_i;
            if (tick_s) begin
                pos_x_q  <= pos_x_i;
                pos_y_q  <= pos_y_i;
                facing_q <= facing_left_i;
            end
        end
    end

    // Animation state and counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            frame_q <= {FRAME_W{1'b0}};
            hold_q  <= {HOLD_W{1'b0}};
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state: everything advances only on the vsync tick.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        if (tick_s) begin
            case (state_q)
                IDLE: begin
                    frame_d = {FRAME_W{1'b0}};
                    hold_d  = {HOLD_W{1'b0}};
                    state_d = running_i ? RUN : IDLE;
                end
                RUN: begin
                    if (!running_i) begin
                        state_d = IDLE;
                        frame_d = {FRAME_W{1'b0}};
                        hold_d  = {HOLD_W{1'b0}};
                    end else if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
                        hold_d  = {HOLD_W{1'b0}};
                        frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ?
                                  {FRAME_W{1'b0}} : frame_q + FRAME_W'(1);
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    frame_d = {FRAME_W{1'b0}};
                    hold_d  = {HOLD_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Outputs: IDLE always presents frame 0.
    always_comb begin
        frame_o       = (state_q == RUN) ? frame_q : {FRAME_W{1'b0}};
        pos_x_o       = pos_x_q;
        pos_y_o       = pos_y_q;
        facing_left_o = facing_q;
    end

endmodule

// File: rtl/run_sprite_fetch.sv
// Per-pixel sprite fetch: inside test, ROM addressing and a 3-cycle aligned
// palette index / coverage / blank output for the downstream palette stage.
module run_sprite_fetch
    import run_sprite_pkg::*;
#(
    parameter int         SPR_W           = DEF_SPR_W,
    parameter int         SPR_H           = DEF_SPR_H,
    parameter int         NUM_FRAMES      = DEF_NUM_FRAMES,
    parameter int         FRAME_HOLD      = DEF_FRAME_HOLD,
    parameter logic [3:0] TRANSPARENT_IDX = DEF_TRANSPARENT_IDX,
    parameter int         ADDR_W          = $clog2(SPR_W * SPR_H * NUM_FRAMES)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank_n,
    input  logic              vs,
    input  logic [9:0]        PosX,
    input  logic [9:0]        PosY,
    input  logic              facing_left,
    input  logic              running,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        sprite_idx,
    output logic              sprite_on,
    output logic              blank_n_out
);

    localparam int FRAME_W = cnt_w(NUM_FRAMES);

    logic [FRAME_W-1:0] frame_s;
    logic [9:0]         pos_x_s, pos_y_s;
    logic               facing_s;

    run_anim_ctrl #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .FRAME_W    (FRAME_W)
    ) u_anim (
        .clk_i         (Clk),
        .rst_ni        (Reset_n),
        .vs_i          (vs),
        .pos_x_i       (PosX),
        .pos_y_i       (PosY),
        .facing_left_i (facing_left),
        .running_i     (running),
        .frame_o       (frame_s),
        .pos_x_o       (pos_x_s),
        .pos_y_o       (pos_y_s),
        .facing_left_o (facing_s)
    );

    logic              inside_s;
    logic [10:0]       lx_s, ly_s, col_s;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic              inside_d1_q, inside_d2_q, blank_d1_q, blank_d2_q;
    logic              opaque_s;
    logic [3:0]        sprite_idx_d, sprite_idx_q;
    logic              sprite_on_q, blank_out_q;

    // 11-bit compares so a sprite near the right/bottom edge clips instead of wrapping.
    always_comb begin
        inside_s = ({1'b0, DrawX} >= {1'b0, pos_x_s}) &&
                   ({1'b0, DrawX} <  ({1'b0, pos_x_s} + 11'(SPR_W))) &&
                   ({1'b0, DrawY} >= {1'b0, pos_y_s}) &&
                   ({1'b0, DrawY} <  ({1'b0, pos_y_s} + 11'(SPR_H)));
        lx_s  = {1'b0, DrawX} - {1'b0, pos_x_s};
        ly_s  = {1'b0, DrawY} - {1'b0, pos_y_s};
        col_s = facing_s ? (11'(SPR_W - 1) - lx_s) : lx_s;
        if (inside_s) begin
            rom_addr_d = ADDR_W'((32'(frame_s) * 32'(SPR_H) + 32'(ly_s)) * 32'(SPR_W)
                                 + 32'(col_s));
        end else begin
            rom_addr_d = {ADDR_W{1'b0}};
        end
    end

    // Output stage decode once the ROM word has arrived.
    always_comb begin
        opaque_s = inside_d2_q && (rom_q != TRANSPARENT_IDX);
        if (opaque_s) begin
            sprite_idx_d = rom_q;
        end else begin
            sprite_idx_d = 4'h0;
        end
    end

    // Address stage, ROM-latency alignment stage and output stage.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q   <= {ADDR_W{1'b0}};
            inside_d1_q  <= 1'b0;
            inside_d2_q  <= 1'b0;
            blank_d1_q   <= 1'b0;
            blank_d2_q   <= 1'b0;
            sprite_idx_q <= 4'h0;
            sprite_on_q  <= 1'b0;
            blank_out_q  <= 1'b0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            inside_d1_q  <= inside_s;
            blank_d1_q   <= blank_n;
            inside_d2_q  <= inside_d1_q;
            blank_d2_q   <= blank_d1_q;
            sprite_idx_q <= sprite_idx_d;
            sprite_on_q  <= opaque_s;
            blank_out_q  <= blank_d2_q;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign sprite_idx  = sprite_idx_q;
    assign sprite_on   = sprite_on_q;
    assign blank_n_out = blank_out_q;

endmodule

// File: tb/tb_run_sprite_fetch.sv
// Directed bench for run_sprite_fetch: stimulus pushes expected address and
// output words into queues; a negedge monitor pops and compares them when due.
module tb_run_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY, PosX, PosY;
    logic        blank_n, vs, facing_left, running;
    logic [12:0] rom_addr;
    logic [3:0]  rom_q;
    logic [3:0]  sprite_idx;
    logic        sprite_on, blank_n_out;

    run_sprite_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank_n     (blank_n),
        .vs          (vs),
        .PosX        (PosX),
        .PosY        (PosY),
        .facing_left (facing_left),
        .running     (running),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .sprite_idx  (sprite_idx),
        .sprite_on   (sprite_on),
        .blank_n_out (blank_n_out)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM model: word = addr[3:0] ^ 5 (address 0 -> 5, address 5 -> transparent 0).
    always @(posedge Clk) rom_q <= rom_addr[3:0] ^ 4'h5;

    int cyc = 0;
    always @(posedge Clk) cyc = cyc + 1;

    typedef struct {
        int          due;
        logic [12:0] addr;
        logic [3:0]  idx;
        logic        on;
        logic        bl;
        string       name;
    } exp_t;

    exp_t addr_q[$];
    exp_t out_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic cmp(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge Clk) begin
        exp_t e;
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            e = addr_q.pop_front();
            cmp({e.name, ".rom_addr"}, int'(rom_addr), int'(e.addr));
        end
        while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            e = out_q.pop_front();
            cmp({e.name, ".sprite_idx"},  int'(sprite_idx),  int'(e.idx));
            cmp({e.name, ".sprite_on"},   int'(sprite_on),   int'(e.on));
            cmp({e.name, ".blank_n_out"}, int'(blank_n_out), int'(e.bl));
        end
    end

    task automatic pix(input int x, input int y, input logic bl, input logic [12:0] ea,
                       input logic [3:0] ei, input logic eo, input string nm);
        exp_t e;
        @(negedge Clk);
        DrawX   = 10'(x);
        DrawY   = 10'(y);
        blank_n = bl;
        e.addr = ea; e.idx = ei; e.on = eo; e.bl = bl; e.name = nm;
        e.due = cyc + 1;
        addr_q.push_back(e);
        e.due = cyc + 3;
        out_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge Clk) vs = 1'b0;
        @(negedge Clk) vs = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; vs = 1'b1; blank_n = 1'b1;
        DrawX = 10'd0; DrawY = 10'd0; PosX = 10'd0; PosY = 10'd0;
        facing_left = 1'b0; running = 1'b0;
        idle(3);
        cmp("reset.rom_addr", int'(rom_addr), 0);
        cmp("reset.sprite_idx", int'(sprite_idx), 0);
        cmp("reset.sprite_on", int'(sprite_on), 0);
        cmp("reset.blank_n_out", int'(blank_n_out), 0);
        Reset_n = 1'b1;

        // Static sprite at (100,200), frame 0.
        PosX = 10'd100; PosY = 10'd200;
        tick(); idle(2);
        pix(100, 200, 1'b1, 13'd0,    4'h5, 1'b1, "origin");
        pix(101, 200, 1'b1, 13'd1,    4'h4, 1'b1, "x+1");
        pix( 99, 200, 1'b1, 13'd0,    4'h0, 1'b0, "left_out");
        pix(131, 247, 1'b1, 13'd1535, 4'hA, 1'b1, "bot_right");
        pix(132, 200, 1'b1, 13'd0,    4'h0, 1'b0, "right_out");
        pix(100, 248, 1'b1, 13'd0,    4'h0, 1'b0, "below_out");
        pix(105, 200, 1'b1, 13'd5,    4'h0, 1'b0, "transparent");
        pix(100, 200, 1'b0, 13'd0,    4'h5, 1'b1, "blanked");
        // Mid-frame position change is ignored until the next tick.
        PosX = 10'd300;
        pix(100, 200, 1'b1, 13'd0,    4'h5, 1'b1, "no_tear");
        idle(4);
        tick(); idle(2);
        pix(300, 200, 1'b1, 13'd0,    4'h5, 1'b1, "moved_in");
        pix(100, 200, 1'b1, 13'd0,    4'h0, 1'b0, "moved_out");
        idle(4);

        // Mirrored.
        PosX = 10'd100; facing_left = 1'b1;
        tick(); idle(2);
        pix(100, 200, 1'b1, 13'd31, 4'hA, 1'b1, "mirror_l");
        pix(131, 200, 1'b1, 13'd0,  4'h5, 1'b1, "mirror_r");
        pix(132, 200, 1'b1, 13'd0,  4'h0, 1'b0, "mirror_out");
        idle(4);

        // Animation: 6 ticks per frame, 4 frames.
        facing_left = 1'b0; running = 1'b1;
        tick(); idle(2);
        pix(100, 200, 1'b1, 13'd0, 4'h5, 1'b1, "run_f0");
        idle(4);
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (t == 5)  begin pix(100, 200, 1'b1, 13'd0,    4'h5, 1'b1, "hold5_f0"); idle(4); end
            if (t == 6)  begin pix(100, 200, 1'b1, 13'd1536, 4'h5, 1'b1, "run_f1");   idle(4); end
            if (t == 12) begin pix(100, 200, 1'b1, 13'd3072, 4'h5, 1'b1, "run_f2");   idle(4); end
            if (t == 18) begin pix(100, 200, 1'b1, 13'd4608, 4'h5, 1'b1, "run_f3");   idle(4); end
            if (t == 24) begin pix(100, 200, 1'b1, 13'd0,    4'h5, 1'b1, "run_wrap"); idle(4); end
        end

        // Drop running while in frame 2.
        repeat (12) tick();
        idle(1);
        pix(100, 200, 1'b1, 13'd3072, 4'h5, 1'b1, "pre_stop_f2");
        idle(4);
        running = 1'b0;
        tick(); idle(1);
        pix(100, 200, 1'b1, 13'd0, 4'h5, 1'b1, "stop_f0");
        idle(4);
        tick(); idle(1);
        pix(100, 200, 1'b1, 13'd0, 4'h5, 1'b1, "idle_f0");
        idle(4);

        // Asynchronous reset mid-run while a steady opaque pixel is being shown.
        running = 1'b1;
        tick();
        repeat (6) tick();
        pix(100, 200, 1'b1, 13'd1536, 4'h5, 1'b1, "pre_reset_f1");
        idle(5);
        #2 Reset_n = 1'b0;
        #1;
        cmp("arst.rom_addr", int'(rom_addr), 0);
        cmp("arst.sprite_idx", int'(sprite_idx), 0);
        cmp("arst.sprite_on", int'(sprite_on), 0);
        cmp("arst.blank_n_out", int'(blank_n_out), 0);
        idle(2);
        Reset_n = 1'b1;
        pix(100, 200, 1'b1, 13'd0, 4'h0, 1'b0, "post_rst_noshadow");
        pix(3,   0,   1'b1, 13'd3, 4'h6, 1'b1, "post_rst_origin0");
        idle(4);
        tick(); idle(1);
        pix(100, 200, 1'b1, 13'd0, 4'h5, 1'b1, "post_rst_latch");
        idle(6);

        cmp("queues_drained", addr_q.size() + out_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
